// File: rtl/plantard_pkg.sv
// Shared constants for the Plantard premultiplier and reducer.
// Holds the default operand width and the standard Q^-1 mod 2^(2W) values.
package plantard_pkg;

    localparam int unsigned W_DEFAULT  = 32;
    localparam int unsigned DW_DEFAULT = 2 * W_DEFAULT;
    localparam int unsigned LATENCY    = 3;

    // Newton iteration for the inverse of an odd q modulo 2^DW_DEFAULT.
    // An odd q is its own inverse mod 8, and each step doubles the number of correct bits.
    function automatic logic [DW_DEFAULT-1:0] qinv_of(input logic [DW_DEFAULT-1:0] q);
        logic [DW_DEFAULT-1:0] x;
        x = q;
        for (int i = 0; i < 6; i++) begin
            x = x * (DW_DEFAULT'(2) - q * x);
        end
        return x;
    endfunction

    localparam logic [DW_DEFAULT-1:0] QINV_KYBER     = qinv_of(DW_DEFAULT'(3329));
    localparam logic [DW_DEFAULT-1:0] QINV_DILITHIUM = qinv_of(DW_DEFAULT'(8380417));

endpackage

// File: rtl/plantard_pipe_reg.sv
// Valid/data pipeline slice: advances when empty or when the downstream slice advances.
module plantard_pipe_reg
    import plantard_pkg::*;
#(
    parameter int unsigned DATA_W = DW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    input  logic              down_adv,
    output logic              adv_c,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    assign adv_c = !valid || down_adv;

    // Data is only written for a real incoming item, so bubbles leave it untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (adv_c) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/plantard_premul.sv
// Plantard premultiplier: A = (a*b*QINV) mod 2^(2W) as a signed value.
// Three elastic slices: operands, exact signed product, product times QINV.
module plantard_premul
    import plantard_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2*W-1:0] QINV,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] A
);

    localparam int unsigned DW = 2 * W;

    logic          adv1, adv2, adv3;
    logic          v1, v2, v3;
    logic [DW-1:0] ab1;
    logic [DW-1:0] p2;
    logic [DW-1:0] a3;
    logic [DW-1:0] a_ext;
    logic [DW-1:0] b_ext;
    logic [DW-1:0] p_next;
    logic [DW-1:0] a_next;

    plantard_pipe_reg #(.DATA_W(DW)) u_s1 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (in_valid),
        .up_data  ({a, b}),
        .down_adv (adv2),
        .adv_c    (adv1),
        .valid    (v1),
        .data     (ab1)
    );

    // Sign-extended operands make the truncated 2W-bit product the exact signed product.
    assign a_ext  = {{W{ab1[DW-1]}}, ab1[DW-1:W]};
    assign b_ext  = {{W{ab1[W-1]}}, ab1[W-1:0]};
    assign p_next = a_ext * b_ext;

    plantard_pipe_reg #(.DATA_W(DW)) u_s2 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (v1),
        .up_data  (p_next),
        .down_adv (adv3),
        .adv_c    (adv2),
        .valid    (v2),
        .data     (p2)
    );

    assign a_next = p2 * QINV;

    plantard_pipe_reg #(.DATA_W(DW)) u_s3 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (v2),
        .up_data  (a_next),
        .down_adv (out_ready),
        .adv_c    (adv3),
        .valid    (v3),
        .data     (a3)
    );

    assign in_ready  = adv1;
    assign out_valid = v3;
    assign A         = a3;

endmodule

// File: tb/tb_plantard_premul.sv
// Bench for plantard_premul at W=8: scoreboard of expected A values checked by an output monitor.
module tb_plantard_premul;

    localparam int unsigned W  = 8;
    localparam int unsigned DW = 16;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic [DW-1:0] QINV      = 16'd1;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a         = '0;
    logic [W-1:0]  b         = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] A;

    int            compared   = 0;
    int            mismatched = 0;
    int            acc_count  = 0;
    int            out_count  = 0;
    int            discarded  = 0;
    int            rdy_mode   = 0;
    logic [DW-1:0] exp_q[$];
    logic          hold       = 1'b0;
    logic [DW-1:0] hold_a     = '0;

    always #5 clk = ~clk;

    plantard_premul #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .QINV      (QINV),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (A)
    );

    // Reference: signed a*b times unsigned QINV, reduced mod 2^16.
    function automatic logic [DW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [DW-1:0] q);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return DW'(p * longint'(q));
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] r;
        case ($urandom_range(0, 7))
            0:       r = 8'h80;
            1:       r = 8'h7F;
            2:       r = 8'hFF;
            3:       r = 8'h00;
            default: r = W'($urandom);
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Accepted pairs: push the expected result.
    always @(negedge clk) begin
        if (rst && in_valid && in_ready) begin
            exp_q.push_back(model(a, b, QINV));
            acc_count++;
        end
    end

    // Output monitor: pop on transfer, and demand stability while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(A), 32'(hold_a));
            end
            if (out_valid && out_ready) begin
                out_count++;
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(A), 32'hFFFF_FFFF);
                end else begin
                    check("out_data", 32'(A), 32'(exp_q.pop_front()));
                end
            end
            hold   = out_valid && !out_ready;
            hold_a = A;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) out_ready = ~out_ready;
        else if (rdy_mode == 2) out_ready = 1'($urandom);
    end

    // Called between posedge+1 and the next negedge; returns at posedge+1 after acceptance.
    task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb);
        bit ok;
        ok       = 1'b0;
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 500; n++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic set_qinv(input logic [DW-1:0] q);
        drain();
        QINV = q;
    endtask

    task automatic directed(input logic [DW-1:0] q, input logic [W-1:0] xa,
                            input logic [W-1:0] xb, input logic [DW-1:0] exp_a);
        int lat;
        set_qinv(q);
        rdy_mode  = 0;
        out_ready = 1'b1;
        send(xa, xb);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd3);
        check("directed_A", 32'(A), 32'(exp_a));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1);
    end

    initial begin
        int seen;
        int gaps;
        int acc0;
        logic [W-1:0] xa;
        logic [W-1:0] xb;

        // Reset state, with the consumer stalled to show in_ready does not depend on it.
        out_ready = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_A", 32'(A), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        directed(16'h0001, 8'h03, 8'h05, 16'h000F);
        directed(16'h0001, 8'hFF, 8'h01, 16'hFFFF);
        directed(16'h0003, 8'h80, 8'h80, 16'hC000);
        directed(16'h5556, 8'h80, 8'h80, 16'h8000);

        // Random streaming with an odd QINV and random input gaps.
        set_qinv(16'($urandom) | 16'd1);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send(rnd_op(), rnd_op());
        end
        drain();

        // Fill with the consumer stalled, then release and expect a gap-free burst of 8.
        out_ready = 1'b0;
        acc0 = acc_count;
        for (int i = 0; i < 3; i++) send(8'(8'h10 + i), 8'(8'h21 + i));
        a        = 8'h13;
        b        = 8'h24;
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("in_ready_full", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        check("accepts_before_full", 32'(acc_count - acc0), 32'd3);
        out_ready = 1'b1;
        seen = 0;
        gaps = 0;
        fork
            begin
                for (int i = 3; i < 8; i++) send(8'(8'h10 + i), 8'(8'h21 + i));
            end
            begin
                for (int n = 0; n < 40 && seen < 8; n++) begin
                    @(negedge clk);
                    if (out_valid) seen++;
                    else if (seen > 0) gaps++;
                end
            end
        join
        check("burst_count", 32'(seen), 32'd8);
        check("burst_gaps", 32'(gaps), 32'd0);
        drain();

        // Alternating, then random, consumer readiness.
        set_qinv(16'($urandom) | 16'd1);
        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) idle(1);
            send(rnd_op(), rnd_op());
        end
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) idle(1);
            send(rnd_op(), rnd_op());
        end
        rdy_mode  = 0;
        out_ready = 1'b1;
        drain();

        // Reset with three items in flight: they must vanish.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rnd_op(), rnd_op());
        #2;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_A", 32'(A), 32'd0);
        discarded += exp_q.size();
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        xa = rnd_op();
        xb = rnd_op();
        directed(QINV, xa, xb, model(xa, xb, QINV));
        drain();

        check("total_outputs", 32'(out_count), 32'(acc_count - discarded));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
